// File: rtl/encoder_fec_pkg.sv
// Shared types and constants for the FEC encoder/decoder pair (16-bit SEC-DED
// extended Hamming codeword carrying an 8-bit message plus 3 zero-pad bits).
package encoder_fec_pkg;

  localparam int MSG_W  = 8;
  localparam int DATA_W = 11;
  localparam int CW_W   = 16;
  localparam int SYN_W  = 4;

  typedef logic [MSG_W-1:0]  message_data_t;
  typedef logic [CW_W-1:0]   encoded_message_data_t;
  typedef logic [DATA_W-1:0] data_bits_t;
  typedef logic [SYN_W-1:0]  syndrome_t;

  typedef enum logic [1:0] {
    NO_ERR,
    CORR,
    UNCORR
  } decode_status_t;

  // Data bits sit at the non-power-of-two positions: d0=cw[3], d3..d1=cw[7:5],
  // d10..d4=cw[15:9].
  function automatic data_bits_t extract_data(input encoded_message_data_t cw);
    return {cw[15:9], cw[7:5], cw[3]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for the 16-bit
// extended Hamming codeword.
module hamming_syndrome
  import encoder_fec_pkg::*;
(
  input  encoded_message_data_t cw,
  output syndrome_t             syndrome,
  output logic                  pa
);

  // Syndrome bit k covers every position whose index has bit k set, so a
  // single error at position i yields syndrome == i.
  always_comb begin
    // NOTE: every combinational output is assigned a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    syndrome = '0;
    for (int i = 1; i < CW_W; i++) begin
      for (int k = 0; k < SYN_W; k++) begin
        if (i[k]) begin
          syndrome[k] = syndrome[k] ^ cw[i];
        end
      end
    end
    pa = ^cw;
  end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage SEC-DED decoder: stage 1 registers codeword, syndrome and parity;
// stage 2 corrects and extracts the message. Optional saturating error
// counters are built when DECODER_ERR_CNT_EN is defined.
module hamming_decoder
  import encoder_fec_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  req,
  input  encoded_message_data_t data_in,
  output logic                  ack,
  output message_data_t         data_out,
  output logic                  err_corrected,
  output logic                  err_uncorrectable
`ifdef DECODER_ERR_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      corr_cnt,
  output logic [CNT_W-1:0]      uncorr_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hamming_decoder: CNT_W must be at least 1");
  end

  // ---------------------------------------------------------------- stage 1
  syndrome_t             syn;
  logic                  pa;
  encoded_message_data_t cw1;
  syndrome_t             s1;
  logic                  pa1;
  logic                  valid1;

  hamming_syndrome u_syndrome (
    .cw       (data_in),
    .syndrome (syn),
    .pa       (pa)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs regardless of statement order.
  // The stage registers are ordinary flops, so all of them are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw1    <= '0;
      s1     <= '0;
      pa1    <= 1'b0;
      valid1 <= 1'b0;
    end else begin
      valid1 <= en & req;
      if (en && req) begin
        cw1 <= data_in;
        s1  <= syn;
        pa1 <= pa;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  decode_status_t        status;
  encoded_message_data_t cw_fix;
  data_bits_t            data_fix;

  always_comb begin
    status = NO_ERR;
    cw_fix = cw1;
    if (s1 != '0) begin
      if (pa1) begin
        cw_fix[s1] = ~cw1[s1];
        status     = CORR;
      end else begin
        status = UNCORR;
      end
    end else if (pa1) begin
      // Only the overall parity bit flipped; data bits are intact.
      status = CORR;
    end
    data_fix = extract_data(cw_fix);
    if (data_fix[DATA_W-1:MSG_W] != '0) begin
      status = UNCORR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack               <= 1'b0;
      data_out          <= '0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
    end else begin
      ack               <= valid1;
      data_out          <= valid1 ? data_fix[MSG_W-1:0] : '0;
      err_corrected     <= valid1 && (status == CORR);
      err_uncorrectable <= valid1 && (status == UNCORR);
    end
  end

`ifdef DECODER_ERR_CNT_EN
  // Counters follow the registered status, so they step on the edge that
  // ends an ack cycle; a clear in that same cycle takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (ack && err_corrected && (corr_cnt != '1)) begin
        corr_cnt <= corr_cnt + 1'b1;
      end
      if (ack && err_uncorrectable && (uncorr_cnt != '1)) begin
        uncorr_cnt <= uncorr_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder; counter checks compile in when
// DECODER_ERR_CNT_EN is defined.
`timescale 1ns/1ps
module tb_hamming_decoder;
  import encoder_fec_pkg::*;

  localparam int CNT_W = 2;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en    = 1'b0;
  logic                  req   = 1'b0;
  encoded_message_data_t data_in = '0;
  logic                  ack;
  message_data_t         data_out;
  logic                  err_corrected;
  logic                  err_uncorrectable;
`ifdef DECODER_ERR_CNT_EN
  logic                  cnt_clr = 1'b0;
  logic [CNT_W-1:0]      corr_cnt;
  logic [CNT_W-1:0]      uncorr_cnt;
`endif

  typedef struct packed {
    message_data_t data;
    logic          corr;
    logic          uncorr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_seen = 0;

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .en                (en),
    .req               (req),
    .data_in           (data_in),
    .ack               (ack),
    .data_out          (data_out),
    .err_corrected     (err_corrected),
    .err_uncorrectable (err_uncorrectable)
`ifdef DECODER_ERR_CNT_EN
    ,
    .cnt_clr           (cnt_clr),
    .corr_cnt          (corr_cnt),
    .uncorr_cnt        (uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoder: data bits fill non-power-of-two positions in order.
  function automatic encoded_message_data_t encode(input logic [10:0] d);
    encoded_message_data_t cw;
    int j;
    logic p;
    cw = '0;
    j  = 0;
    for (int i = 1; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int i = 1; i < 16; i++) if (i[k]) p = p ^ cw[i];
      cw[1 << k] = p;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic message_data_t raw_msg(input encoded_message_data_t cw);
    message_data_t m;
    int j;
    m = '0;
    j = 0;
    for (int i = 1; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (j < 8) m[j] = cw[i];
        j++;
      end
    end
    return m;
  endfunction

  function automatic exp_t mk(input message_data_t d, input logic c, input logic u);
    exp_t e;
    e.data = d; e.corr = c; e.uncorr = u;
    return e;
  endfunction

  // Scoreboard monitor: compares every ack against the oldest expectation and
  // checks that idle cycles drive all-zero outputs.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      n_checks++;
      if (ack === 1'b1) begin
        ack_seen++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: got data_out=%h corr=%b uncorr=%b, required no ack",
                   data_out, err_corrected, err_uncorrectable);
        end else begin
          e = sb.pop_front();
          if ({data_out, err_corrected, err_uncorrectable} !== e) begin
            n_fail++;
            $display("FAIL scoreboard: got data_out=%h corr=%b uncorr=%b, required data_out=%h corr=%b uncorr=%b",
                     data_out, err_corrected, err_uncorrectable, e.data, e.corr, e.uncorr);
          end
        end
      end else if ({ack, data_out, err_corrected, err_uncorrectable} !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs: got ack=%b data_out=%h corr=%b uncorr=%b, required all 0",
                 ack, data_out, err_corrected, err_uncorrectable);
      end
    end
  endtask

  task automatic send(input encoded_message_data_t cw, input exp_t e);
    @(posedge clk); #1;
    en = 1'b1; req = 1'b1; data_in = cw;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req = 1'b0; data_in = '0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d words outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ack, data_out, err_corrected, err_uncorrectable} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b data_out=%h, required 0", ack, data_out);
    end
`ifdef DECODER_ERR_CNT_EN
    n_checks++;
    if ({corr_cnt, uncorr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got corr=%0d uncorr=%0d, required 0", corr_cnt, uncorr_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    send(16'h144E, mk(8'hA5, 1'b0, 1'b0)); idle();
    send(16'h146E, mk(8'hA5, 1'b1, 1'b0)); idle();
    send(16'h144F, mk(8'hA5, 1'b1, 1'b0)); idle();
    send(16'h166E, mk(8'hB7, 1'b0, 1'b1)); idle();
    send(16'h2112, mk(8'h00, 1'b0, 1'b1)); idle();
    drain("directed");
  endtask

  task automatic test_back_to_back();
    int base;
    base = ack_seen;
    send(16'h144E, mk(8'hA5, 1'b0, 1'b0));
    send(16'h146E, mk(8'hA5, 1'b1, 1'b0));
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got ack=%b one cycle after request, required 0", ack);
    end
    send(16'h0000, mk(8'h00, 1'b0, 1'b0));
    n_checks++;
    if (ack !== 1'b1 || data_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL latency_two: got ack=%b data_out=%h, required ack=1 data_out=a5", ack, data_out);
    end
    idle();
    drain("back_to_back");
    n_checks++;
    if (ack_seen - base != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d acks, required 3", ack_seen - base);
    end
    // en low masks req; a word already in flight still completes.
    base = ack_seen;
    send(16'h144E, mk(8'hA5, 1'b0, 1'b0));
    @(posedge clk); #1;
    en = 1'b0; req = 1'b1; data_in = 16'h146E;
    repeat (4) @(posedge clk);
    #1;
    req = 1'b0; en = 1'b1;
    drain("en_low");
    n_checks++;
    if (ack_seen - base != 1) begin
      n_fail++;
      $display("FAIL en_low_count: got %0d acks, required 1", ack_seen - base);
    end
  endtask

  task automatic test_random();
    logic [10:0]           d;
    encoded_message_data_t cw;
    int                    nflip;
    int                    p1;
    int                    p2;
    for (int n = 0; n < 60; n++) begin
      d     = {3'b000, 8'($urandom)};
      cw    = encode(d);
      nflip = $urandom_range(0, 2);
      p1    = $urandom_range(0, 15);
      p2    = (p1 + $urandom_range(1, 15)) % 16;
      if (nflip == 0) begin
        send(cw, mk(d[7:0], 1'b0, 1'b0));
      end else if (nflip == 1) begin
        cw[p1] = ~cw[p1];
        send(cw, mk(d[7:0], 1'b1, 1'b0));
      end else begin
        cw[p1] = ~cw[p1];
        cw[p2] = ~cw[p2];
        send(cw, mk(raw_msg(cw), 1'b0, 1'b1));
      end
    end
    idle();
    drain("random");
  endtask

  task automatic test_reset_mid();
    int base;
    base = ack_seen;
    send(16'h144E, mk(8'hA5, 1'b0, 1'b0));
    idle();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (ack_seen != base) begin
      n_fail++;
      $display("FAIL reset_mid: got %0d acks after reset, required 0", ack_seen - base);
    end
  endtask

`ifdef DECODER_ERR_CNT_EN
  task automatic test_counters();
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_checks++;
    if ({corr_cnt, uncorr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL cnt_clear: got corr=%0d uncorr=%0d, required 0", corr_cnt, uncorr_cnt);
    end
    for (int i = 0; i < 5; i++) send(16'h146E, mk(8'hA5, 1'b1, 1'b0));
    idle();
    drain("cnt_sat");
    @(posedge clk); #1;
    n_checks++;
    if (corr_cnt !== 2'd3 || uncorr_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL cnt_saturate: got corr=%0d uncorr=%0d, required corr=3 uncorr=0", corr_cnt, uncorr_cnt);
    end
    send(16'h166E, mk(8'hB7, 1'b0, 1'b1));
    idle();
    drain("cnt_uncorr");
    @(posedge clk); #1;
    n_checks++;
    if (uncorr_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL cnt_uncorr: got uncorr=%0d, required 1", uncorr_cnt);
    end
    send(16'h146E, mk(8'hA5, 1'b1, 1'b0));
    idle();
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL cnt_clr_ack: got ack=%b, required 1", ack);
    end
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_checks++;
    if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL cnt_clr_wins: got corr=%0d uncorr=%0d, required 0", corr_cnt, uncorr_cnt);
    end
    drain("cnt_clr");
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
`ifdef DECODER_ERR_CNT_EN
    test_counters();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
